// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: 8-digit multiplexed seven-segment scanner with shadow/active digit registers and frame-synchronous commit.
// Ports: clk/rst (sync, active-high); wr_valid/wr_ready/wr_addr/wr_data write one shadow nibble;
// digit_en masks digits; commit/commit_done copy shadow to active at the frame boundary;
// frame_start marks the first displayed cycle of digit 0; seg/an are registered active-low drives.
// Build option: define SSD_BLANK_EN to insert BLANK_CYCLES of blanking after every digit slot.
module ssd_scan_ctrl #(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [7:0] digit_en,
  input  logic       commit,
  output logic       commit_done,
  output logic       frame_start,
  output logic [6:0] seg,
  output logic [7:0] an
);
`ifdef SSD_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif
  localparam int CW = $clog2(TICK_DIV + BLANK_CYCLES);
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef enum logic {SHOW, BLANK} state_t;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_idx;
  logic             r_pending;
  logic [7:0][3:0]  r_shadow;
  logic [7:0][3:0]  r_active;
  logic             w_slot_end;
  logic             w_blank_end;
  logic             w_adv;
  logic             w_bnd;
  logic             w_pending_nxt;
  logic             w_wr;
  logic [6:0]       w_glyph;
  assign w_slot_end    = r_state == SHOW && r_cnt == CW'(TICK_DIV - 1);
  assign w_blank_end   = BLANK_EN && r_state == BLANK && r_cnt == CW'(BLANK_CYCLES - 1);
  // The digit index moves on when the whole slot (show plus optional blank) is over.
  assign w_adv         = BLANK_EN ? w_blank_end : w_slot_end;
  assign w_bnd         = w_adv && r_idx == 3'd7;
  // A commit seen while one is already pending is dropped; the boundary clears pending.
  assign w_pending_nxt = r_pending ? !w_bnd : commit;
  assign w_wr          = wr_valid && wr_ready;
  assign w_glyph       = GLYPH[r_active[r_idx]];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SHOW;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_pending   <= 1'b0;
      r_shadow    <= '0;
      r_active    <= '0;
      wr_ready    <= 1'b0;
      commit_done <= 1'b0;
      frame_start <= 1'b0;
      seg         <= 7'h7F;
      an          <= 8'hFF;
    end else begin
      r_cnt       <= (w_slot_end || w_blank_end) ? '0 : r_cnt + 1'b1;
      r_state     <= (w_slot_end && BLANK_EN) ? BLANK : w_blank_end ? SHOW : r_state;
      r_idx       <= w_adv ? r_idx + 3'd1 : r_idx;
      r_pending   <= w_pending_nxt;
      if (w_wr) r_shadow[wr_addr] <= wr_data;
      if (r_pending && w_bnd) r_active <= r_shadow;
      wr_ready    <= !w_pending_nxt;
      commit_done <= r_pending && w_bnd;
      // Outputs are registered from the current slot state, so they trail the slot start by one clock.
      frame_start <= r_state == SHOW && r_cnt == '0 && r_idx == 3'd0;
      an          <= (r_state == SHOW && digit_en[r_idx]) ? ~(8'd1 << r_idx) : 8'hFF;
      seg         <= r_state == SHOW ? w_glyph : 7'h7F;
    end
  end
endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000: clock cycles per digit display slot; legal range 2 or more.
REQ-002 SHALL have parameter BLANK_CYCLES, default 16: cycles of inter-digit blanking; legal range 1 or more; used only with SSD_BLANK_EN.
REQ-003 SHALL have port clk  input  1  system clock; the only clock in the block.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port wr_valid  input  1  shadow-register write request.
REQ-006 SHALL have port wr_ready  output  1  write port can accept a write.
REQ-007 SHALL have port wr_addr  input  3  digit index 0-7.
REQ-008 SHALL have port wr_data  input  4  hex nibble 0x0-0xF.
REQ-009 SHALL have port digit_en  input  8  per-digit enable mask; bit n enables digit n.
REQ-010 SHALL have port commit  input  1  request to copy shadow to active.
REQ-011 SHALL have port commit_done  output  1  one-cycle pulse when the copy occurs.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse at digit-0 slot start.
REQ-013 SHALL have port seg  output  7  active-low segments, bit0=a through bit6=g.
REQ-014 SHALL have port an  output  8  active-low anodes, bit n = digit n.

Function
REQ-015 SHALL hold 8x4-bit shadow and 8x4-bit active registers; only active drives the display.
REQ-016 SHALL accept a write on the cycle wr_valid and wr_ready are both 1, writing wr_data into shadow[wr_addr].
REQ-017 SHALL hold wr_ready at 1 except while a commit is pending, when it is 0.
REQ-018 SHALL set commit-pending on a commit pulse; a commit while already pending is ignored.
REQ-019 SHALL include a write accepted in the same cycle as the commit pulse in the committed data.
REQ-020 SHALL, at the frame boundary (slot end of digit 7), copy shadow to active, clear pending, and pulse commit_done for exactly that cycle.
REQ-021 SHALL use a prescaler counting 0 to TICK_DIV-1 per SHOW slot; the digit index advances 7 to 0 with wrap-around.
REQ-022 SHALL, in a slot, drive an low only at bit idx when digit_en[idx]=1, and drive an=8'hFF otherwise; a disabled digit still consumes its slot so the frame rate is constant.
REQ-023 SHALL decode active[idx] to standard hex 0-F glyphs (0x0 = 7'b1000000, 0x8 = 7'b0000000).
REQ-024 SHALL register an and seg, so they reflect a new slot exactly one clock after the internal slot start.
REQ-025 SHALL pulse frame_start for one cycle on the first cycle of each digit-0 SHOW slot.
REQ-026 SHALL sample digit_en every cycle; a change takes effect on the next cycle's outputs.

Reset
REQ-027 SHALL, with rst=1 at a clk edge, set an=8'hFF, seg=7'h7F, wr_ready=0, commit_done=0, frame_start=0, pending=0, prescaler=0, index=0, state=SHOW, and all shadow and active registers to 0.
REQ-028 SHALL release wr_ready to 1 on the first cycle after rst falls; scanning restarts at digit 0, and the first frame_start occurs in that same first cycle.
REQ-029 SHALL abort any pending commit on reset mid-operation; the active registers are not updated.

Configuration
REQ-030 SHALL use macro SSD_BLANK_EN: when defined, FSM states are SHOW (TICK_DIV cycles) then BLANK (BLANK_CYCLES cycles, an=8'hFF, seg=7'h7F), and the index advances at BLANK end; frame period is 8*(TICK_DIV+BLANK_CYCLES).
REQ-031 SHALL, with SSD_BLANK_EN undefined, go directly SHOW to SHOW, ignore BLANK_CYCLES, and have a frame period of 8*TICK_DIV.

Verification (TICK_DIV=4, BLANK_CYCLES=2)
REQ-032 SHALL cover: reset, then write 0x1-0x8 to digits 0-7, no commit -> all lit digits show 7'b1000000; an cycles FE,FD,...,7F every 4 clocks.
REQ-033 SHALL cover: commit after those writes -> wr_ready=0 until the boundary; commit_done pulses once; the next frame shows digit0=7'b1111001 ("1").
REQ-034 SHALL cover: digit_en=8'b00000101 -> an shows only FE and FB; other slots are FF; frame_start period stays 32 clocks.
REQ-035 SHALL cover: write to addr 3 coincident with commit -> the new digit3 value appears after commit_done; a second commit while pending produces no extra commit_done.
REQ-036 SHALL cover: rst asserted while a commit is pending -> an=FF, seg=7F, no commit_done, active stays 0.
REQ-037 SHALL cover: with SSD_BLANK_EN -> 2 blank cycles (an=FF) after each 4-cycle slot, and a frame_start period of 48 clocks.
